// File: rtl/xorshift256p_checker.sv
// Xorshift256+ stream checker: regenerates the expected 64-bit sequence from
// a 256-bit seed and compares it against observed words over valid/ready.
module xorshift256p_checker #(
  parameter int unsigned CHECK_LEN = 1024,
  parameter int unsigned ERR_W     = 16,
  parameter int unsigned IDX_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [255:0]     seed,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             seed_zero,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [IDX_W-1:0] word_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t      state;
  logic [63:0] s0, s1, s2, s3;

  logic [63:0] exp_word;
  logic [63:0] t, a0, a1, a2, a3;
  logic [63:0] n0, n1, n2, n3;
  logic        accept, bad, last, err_full;
  logic [IDX_W-1:0] idx_inc;

  // Expected word and next generator state as one sequential xor chain,
  // each stage reading the already-updated words of the previous stage.
  always_comb begin
    exp_word = s0 + s3;
    t        = s1 << 17;
    a2       = s2 ^ s0;
    a3       = s3 ^ s1;
    a1       = s1 ^ a2;
    a0       = s0 ^ a3;
    n0       = a0;
    n1       = a1;
    n2       = a2 ^ t;
    n3       = {a3[18:0], a3[63:19]};
  end

  // Handshake, compare result and run-termination detection.
  always_comb begin
    accept   = in_ready & in_valid;
    bad      = accept & (in_data != exp_word);
    idx_inc  = word_idx + 1'b1;
    last     = (CHECK_LEN != 0) && (idx_inc == IDX_W'(CHECK_LEN));
    err_full = &err_count;
  end

  // Control FSM with registered status outputs and result counters.
  // The seed is captured straight into s0..s3 on the accepted start so no
  // separate 256-bit seed register is needed; LOAD then only inspects it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s0            <= '0;
      s1            <= '0;
      s2            <= '0;
      s3            <= '0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      seed_zero     <= 1'b0;
      mismatch      <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      word_idx      <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            s0    <= seed[63:0];
            s1    <= seed[127:64];
            s2    <= seed[191:128];
            s3    <= seed[255:192];
            state <= LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        LOAD: begin
          err_count     <= '0;
          first_err_idx <= '0;
          word_idx      <= '0;
          if ({s3, s2, s1, s0} == '0) begin
            state     <= DONE;
            seed_zero <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
          end else begin
            state     <= RUN;
            seed_zero <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            s0       <= n0;
            s1       <= n1;
            s2       <= n2;
            s3       <= n3;
            word_idx <= idx_inc;
            mismatch <= bad;
            if (bad) begin
              if (!err_full)
                err_count <= err_count + 1'b1;
              if (err_count == '0)
                first_err_idx <= word_idx;
            end
            if (last) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_count == '0) && !bad;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xorshift256p_checker.sv
// Bench for xorshift256p_checker: two instances (short run / narrow error
// counter) driven with directed and random runs against a sequence model.
module tb_xorshift256p_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_v [2];
  logic [255:0] seed_v  [2];
  logic         inv_v   [2];
  logic [63:0]  ind_v   [2];
  logic         rdy_v   [2];
  logic         busy_v  [2];
  logic         done_v  [2];
  logic         pass_v  [2];
  logic         sz_v    [2];
  logic         mm_v    [2];
  logic [31:0]  fe_v    [2];
  logic [31:0]  wi_v    [2];
  logic [15:0]  err_a;
  logic [1:0]   err_b;

  xorshift256p_checker #(.CHECK_LEN(3), .ERR_W(16), .IDX_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .seed(seed_v[0]),
    .in_valid(inv_v[0]), .in_data(ind_v[0]), .in_ready(rdy_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .seed_zero(sz_v[0]), .mismatch(mm_v[0]), .err_count(err_a),
    .first_err_idx(fe_v[0]), .word_idx(wi_v[0])
  );

  xorshift256p_checker #(.CHECK_LEN(6), .ERR_W(2), .IDX_W(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .seed(seed_v[1]),
    .in_valid(inv_v[1]), .in_data(ind_v[1]), .in_ready(rdy_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .seed_zero(sz_v[1]), .mismatch(mm_v[1]), .err_count(err_b),
    .first_err_idx(fe_v[1]), .word_idx(wi_v[1])
  );

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [63:0] expw [0:15];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] errv(input int u);
    return (u == 0) ? {48'b0, err_a} : {62'b0, err_b};
  endfunction

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  // Reference sequence: word k = s0+s3 after k generator steps.
  task automatic gen(input logic [255:0] sd, input int n);
    logic [63:0] s [4];
    logic [63:0] tt;
    for (int i = 0; i < 4; i++) s[i] = sd[64*i +: 64];
    for (int k = 0; k < n; k++) begin
      expw[k] = s[0] + s[3];
      tt   = s[1] << 17;
      s[2] = s[2] ^ s[0];
      s[3] = s[3] ^ s[1];
      s[1] = s[1] ^ s[2];
      s[0] = s[0] ^ s[3];
      s[2] = s[2] ^ tt;
      s[3] = rotl64(s[3], 45);
    end
  endtask

  task automatic check_reset_vals(input int u);
    check("rst_ready", {63'b0, rdy_v[u]}, 0);
    check("rst_busy",  {63'b0, busy_v[u]}, 0);
    check("rst_done",  {63'b0, done_v[u]}, 0);
    check("rst_pass",  {63'b0, pass_v[u]}, 0);
    check("rst_sz",    {63'b0, sz_v[u]}, 0);
    check("rst_mm",    {63'b0, mm_v[u]}, 0);
    check("rst_err",   errv(u), 0);
    check("rst_fe",    {32'b0, fe_v[u]}, 0);
    check("rst_wi",    {32'b0, wi_v[u]}, 0);
  endtask

  // One run on unit u: feed nfeed words, corrupting those flagged in emask.
  task automatic run(input int u, input logic [255:0] sd, input int nfeed,
                     input logic [15:0] emask, input bit stalls, input bit expect_done);
    int len, k, errs, first, cyc, satmax;
    bit v, wrong;
    len    = (u == 0) ? 3 : 6;
    satmax = (u == 0) ? 65535 : 3;
    gen(sd, nfeed);
    @(negedge clk);
    start_v[u] = 1'b1;
    seed_v[u]  = sd;
    @(negedge clk);
    start_v[u] = 1'b0;
    seed_v[u]  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    check("load_busy",  {63'b0, busy_v[u]}, 1);
    check("load_ready", {63'b0, rdy_v[u]}, 0);
    check("load_done",  {63'b0, done_v[u]}, 0);
    @(negedge clk);
    if (sd == '0) begin
      check("zs_done",  {63'b0, done_v[u]}, 1);
      check("zs_sz",    {63'b0, sz_v[u]}, 1);
      check("zs_pass",  {63'b0, pass_v[u]}, 0);
      check("zs_busy",  {63'b0, busy_v[u]}, 0);
      check("zs_err",   errv(u), 0);
      check("zs_wi",    {32'b0, wi_v[u]}, 0);
      for (int i = 0; i < 3; i++) begin
        check("zs_ready", {63'b0, rdy_v[u]}, 0);
        @(negedge clk);
      end
      return;
    end
    check("run_sz",  {63'b0, sz_v[u]}, 0);
    check("run_err", errv(u), 0);
    check("run_wi",  {32'b0, wi_v[u]}, 0);
    check("run_fe",  {32'b0, fe_v[u]}, 0);
    k = 0; errs = 0; first = 0; cyc = 0;
    while (k < nfeed && cyc < 1000) begin
      check("ready", {63'b0, rdy_v[u]}, 1);
      v = stalls ? ($urandom_range(0, 1) == 1) : 1'b1;
      wrong = emask[k];
      inv_v[u] = v;
      ind_v[u] = expw[k] ^ (wrong ? ({$urandom, $urandom} | 64'h1) : 64'h0);
      @(negedge clk);
      inv_v[u] = 1'b0;
      if (v) begin
        if (wrong) begin
          if (errs == 0) first = k;
          errs++;
        end
        k++;
        check("mismatch", {63'b0, mm_v[u]}, {63'b0, wrong});
        check("word_idx", {32'b0, wi_v[u]}, k);
        check("err_count", errv(u), (errs > satmax) ? satmax : errs);
        check("first_err", {32'b0, fe_v[u]}, first);
      end else begin
        check("stall_mm", {63'b0, mm_v[u]}, 0);
        check("stall_wi", {32'b0, wi_v[u]}, k);
      end
      cyc++;
    end
    inv_v[u] = 1'b0;
    if (cyc >= 1000) check("timeout", 1, 0);
    if (expect_done) begin
      check("end_done",  {63'b0, done_v[u]}, 1);
      check("end_ready", {63'b0, rdy_v[u]}, 0);
      check("end_busy",  {63'b0, busy_v[u]}, 0);
      check("end_pass",  {63'b0, pass_v[u]}, (errs == 0) ? 1 : 0);
      @(negedge clk);
      check("hold_done", {63'b0, done_v[u]}, 1);
      check("hold_wi",   {32'b0, wi_v[u]}, len);
      check("hold_mm",   {63'b0, mm_v[u]}, 0);
    end else begin
      check("mid_done", {63'b0, done_v[u]}, 0);
      check("mid_busy", {63'b0, busy_v[u]}, 1);
    end
  endtask

  initial begin
    logic [255:0] sd;
    logic [15:0]  em;
    int u;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0; seed_v[i] = '0; inv_v[i] = 1'b0; ind_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst = 1'b0;

    gen(256'h1, 3);
    check("model_w0", expw[0], 64'h1);
    check("model_w1", expw[1], 64'h1);
    check("model_w2", expw[2], 64'h0000200000000000);

    run(0, 256'h1, 3, 16'h0000, 1'b0, 1'b1);
    check("s1_err", errv(0), 0);
    run(0, 256'h1, 3, 16'h0002, 1'b0, 1'b1);
    check("s2_fe", {32'b0, fe_v[0]}, 1);
    run(0, 256'h1, 3, 16'h0000, 1'b1, 1'b1);
    run(0, 256'h0, 0, 16'h0000, 1'b0, 1'b1);
    run(1, 256'h1, 6, 16'h003f, 1'b0, 1'b1);
    check("sat_err", errv(1), 3);
    check("sat_fe", {32'b0, fe_v[1]}, 0);

    run(0, 256'h1, 2, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_vals(0);
    @(negedge clk);
    rst = 1'b0;
    run(0, 256'h1, 3, 16'h0000, 1'b0, 1'b1);
    run(1, 256'h1, 6, 16'h0000, 1'b1, 1'b1);

    for (int r = 0; r < 24; r++) begin
      u  = $urandom_range(0, 1);
      sd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      em = '0;
      for (int b = 0; b < 6; b++) em[b] = ($urandom_range(0, 3) == 0);
      run(u, sd, (u == 0) ? 3 : 6, em, 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/xorshift256p_checker.md
# xorshift256p_checker

Stream checker for Xorshift256+ output. It is seeded with the same 256-bit seed as the generator under test and regenerates the expected 64-bit sequence internally. It accepts observed words over a valid/ready handshake, compares each one to the expected value, and reports the mismatch count, the index of the first failure, and a pass/fail verdict. It sits at the receiving end of any PRNG stream (loopback, BIST, link test) and forms the consumer half of the generator.

## Interface
- CHECK_LEN, 1024: number of words to check per run; 0 = unbounded, the run never reaches DONE.
- ERR_W, 16: width of `err_count`; the count saturates at all-ones.
- IDX_W, 32: width of the word index and `first_err_idx`.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled in IDLE and DONE only.
- seed  input  256  {s3,s2,s1,s0}; sampled on the accepted `start` cycle.
- in_valid  input  1  observed word present.
- in_data  input  64  observed word.
- in_ready  output  1  high only in RUN.
- busy  output  1  high in LOAD and RUN.
- done  output  1  high in DONE.
- pass  output  1  valid when `done`; 1 iff `err_count`==0 and the seed was nonzero.
- seed_zero  output  1  set when the sampled seed was all zeros.
- mismatch  output  1  one-cycle pulse the cycle after a failed compare.
- err_count  output  ERR_W  number of failed compares, saturating.
- first_err_idx  output  IDX_W  index of the first failed word; 0 when there are no errors.
- word_idx  output  IDX_W  number of words accepted in the current run.

## Operation
- Expected word for the current state: e = s0 + s3, modulo 2^64.
- Step, applied on every accepted word in this order: t = s1<<17; s2^=s0; s3^=s1; s1^=s2; s0^=s3; s2^=t; s3 = rotl64(s3,45).
- Each step reads the current values. Implement it as a combinational next-state chain; do not use parallel non-blocking updates of the partially updated words.
- Word k (0-based) is compared against e computed from the state after k steps from the seed.
- States:
  - IDLE → LOAD on `start`.
  - LOAD (1 cycle): load s0..s3 from `seed`; clear `err_count`, `first_err_idx`, `word_idx`, `seed_zero`.
    - If the seed is all zeros → DONE with `seed_zero`=1 and `pass`=0.
    - Otherwise → RUN.
  - RUN: on `in_valid & in_ready`, compare `in_data` to e, advance the state, and increment `word_idx`.
    - On a mismatch, increment `err_count` (saturating). If this is the first error, latch the current `word_idx` into `first_err_idx`.
    - → DONE when the incremented `word_idx` equals CHECK_LEN (CHECK_LEN≠0).
  - DONE: hold all results. `start` → LOAD (rerun with the new seed).
- `start` is ignored in LOAD and RUN.
- A cycle with `in_valid`=0 in RUN is a stall: no compare, no step, no index change.
- `word_idx` wraps modulo 2^IDX_W in unbounded mode, and `first_err_idx` is unaffected by the wrap.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `pass`=0, `seed_zero`=0, `mismatch`=0, and all counters and indices 0. State is IDLE, and s0..s3 are 0.
- Reset asserted mid-run aborts immediately to these values. No compare is recorded in that cycle.
- `start` accepted at cycle n → LOAD at n+1 → RUN at n+2, so `in_ready`=1 from n+2.
- A word accepted at cycle m updates `err_count`, `first_err_idx`, and `word_idx` at m+1, and `mismatch` pulses at m+1.
- The last word (index CHECK_LEN-1) accepted at m → `done`=1 and a valid `pass` at m+1. `in_ready` is 0 from m+1.
- Back-to-back words are checked at full rate (one per cycle), with no bubbles.

## Test plan
- Seed {0,0,0,1}, CHECK_LEN=3, feed 0x1, 0x1, 0x0000200000000000 → `done` one cycle after the third word, `pass`=1, `err_count`=0, `word_idx`=3.
- Same seed, feed 0x1, 0x5, 0x0000200000000000 → one `mismatch` pulse one cycle after word 1, `err_count`=1, `first_err_idx`=1, `pass`=0.
- Same seed with `in_valid` toggled randomly in RUN → results identical to the first scenario; no step occurs on stall cycles.
- Seed all zeros → `done` two cycles after `start`, `seed_zero`=1, `pass`=0, `in_ready` never asserts.
- ERR_W=2, CHECK_LEN=6, all six words wrong → `err_count` saturates at 3, `first_err_idx`=0.
- Assert `rst` after 2 words of a run, then restart with the same seed → all outputs return to reset values; the second run checks from word 0 and passes against the first-scenario values.
